// File: rtl/sales_pkg.sv
// Shared types and constants for the sales accumulator arbiter and its divider.
package sales_pkg;

    localparam int SALES_W    = 32;
    localparam int DIV_CYCLES = SALES_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DIV   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sales_div.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, W cycles per
// division. The quotient is valid combinationally in the cycle done is high.
module sales_div
    import sales_pkg::*;
#(
    parameter int W = SALES_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic [W-1:0]  rem_in, quo_in;
    logic [W:0]    rem_sh, diff;

    // NOTE: every variable gets a default at the top of always_comb, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rem_in   = start ? '0 : rem_q;
        quo_in   = start ? dividend : quo_q;
        rem_sh   = {rem_in, quo_in[W-1]};
        diff     = rem_sh - {1'b0, divisor};
        rem_d    = rem_sh[W-1:0];
        quo_d    = {quo_in[W-2:0], 1'b0};
        cnt_d    = cnt_q;
        active_d = active_q;
        done     = 1'b0;
        if (!diff[W]) begin
            rem_d = diff[W-1:0];
            quo_d = {quo_in[W-2:0], 1'b1};
        end
        if (start) begin
            cnt_d    = CW'(1);
            active_d = 1'b1;
        end else if (active_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                done     = 1'b1;
                active_d = 1'b0;
            end
        end
        quotient = quo_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // NOTE: the partial remainder/quotient are reloaded by start, so they carry no reset.
    always_ff @(posedge clk) begin
        if (start || active_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

endmodule

// File: rtl/sales_arb.sv
// Round-robin arbiter sharing one sales accumulator and divider among LANES lanes.
// Define SALES_OVF_EN to build the sticky overflow detector driving ovf.
module sales_arb
    import sales_pkg::*;
#(
    parameter int LANES = 4,
    parameter int W     = SALES_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES-1:0]   req,
    input  logic [LANES*W-1:0] price_i,
    input  logic [LANES*W-1:0] num_i,
    input  logic               clr,
    output logic [LANES-1:0]   ack,
    output logic               busy,
    output logic [W-1:0]       avg,
    output logic               avg_valid,
    output logic               ovf
);

    localparam int LW  = $clog2(LANES);
    localparam int LWP = LW + 1;

    state_t         state_q, state_d;
    logic [LW-1:0]  rr_q, rr_d, gnt_q, gnt_d;
    logic [W-1:0]   price_q, price_d, num_q, num_d;
    logic [W-1:0]   amount_q, amount_d, total_q, total_d, avg_q, avg_d;
    logic           div_start_q, div_start_d;

    logic [2*LANES-1:0] req_rot;
    logic               any_req;
    logic [LW-1:0]      off, pick;
    logic [LW:0]        pick_sum;
    logic [W-1:0]       price_sel, num_sel;
    logic [W-1:0]       prod_lo, amount_sum, total_sum;
    logic [W-1:0]       div_quo;
    logic               div_done;

    // Rotate requests so bit 0 is the lane at the rr pointer; the first set bit wins.
    assign req_rot = {req, req} >> rr_q;

    always_comb begin
        any_req = 1'b0;
        off     = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!any_req && req_rot[i]) begin
                any_req = 1'b1;
                off     = LW'(i);
            end
        end
        pick_sum = {1'b0, rr_q} + {1'b0, off};
        if (pick_sum >= LWP'(LANES)) pick_sum = pick_sum - LWP'(LANES);
        pick      = pick_sum[LW-1:0];
        price_sel = '0;
        num_sel   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (pick == LW'(i)) begin
                price_sel = price_i[i*W +: W];
                num_sel   = num_i[i*W +: W];
            end
        end
    end

`ifdef SALES_OVF_EN
    logic [2*W-1:0] prod_full;
    logic [W:0]     amount_wide, total_wide;
    logic           ovf_q;

    assign prod_full   = {{W{1'b0}}, price_q} * {{W{1'b0}}, num_q};
    assign prod_lo     = prod_full[W-1:0];
    assign amount_wide = {1'b0, amount_q} + {1'b0, prod_lo};
    assign total_wide  = {1'b0, total_q} + {1'b0, num_q};
    assign amount_sum  = amount_wide[W-1:0];
    assign total_sum   = total_wide[W-1:0];

    always_ff @(posedge clk) begin
        if (rst || (state_q == S_IDLE && clr)) begin
            ovf_q <= 1'b0;
        end else if (state_q == S_ACCUM &&
                     ((|prod_full[2*W-1:W]) || amount_wide[W] || total_wide[W])) begin
            ovf_q <= 1'b1;
        end
    end
    assign ovf = ovf_q;
`else
    assign prod_lo    = price_q * num_q;
    assign amount_sum = amount_q + prod_lo;
    assign total_sum  = total_q + num_q;
    assign ovf        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        price_d     = price_q;
        num_d       = num_q;
        amount_d    = amount_q;
        total_d     = total_q;
        avg_d       = avg_q;
        div_start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    amount_d = '0;
                    total_d  = '0;
                    avg_d    = '0;
                end else if (any_req) begin
                    gnt_d   = pick;
                    price_d = price_sel;
                    num_d   = num_sel;
                    rr_d    = (pick == LW'(LANES - 1)) ? '0 : pick + LW'(1);
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                amount_d = amount_sum;
                total_d  = total_sum;
                // A zero divisor skips the divider and reports a zero average.
                if (total_sum == '0) begin
                    avg_d   = '0;
                    state_d = S_DONE;
                end else begin
                    div_start_d = 1'b1;
                    state_d     = S_DIV;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    avg_d   = div_quo;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            gnt_q       <= '0;
            price_q     <= '0;
            num_q       <= '0;
            amount_q    <= '0;
            total_q     <= '0;
            avg_q       <= '0;
            div_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            price_q     <= price_d;
            num_q       <= num_d;
            amount_q    <= amount_d;
            total_q     <= total_d;
            avg_q       <= avg_d;
            div_start_q <= div_start_d;
        end
    end

    sales_div #(.W(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_q),
        .dividend (amount_q),
        .divisor  (total_q),
        .quotient (div_quo),
        .done     (div_done)
    );

    always_comb begin
        ack = '0;
        if (state_q == S_ACCUM) ack[gnt_q] = 1'b1;
    end

    assign busy      = (state_q != S_IDLE);
    assign avg       = avg_q;
    assign avg_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_sales_arb.sv
// Scoreboard bench for sales_arb: expected grants and averages are queued as
// stimulus is driven and popped when ack / avg_valid appear.
module tb_sales_arb;

    localparam int LANES = 4;
    localparam int W     = 32;
    localparam logic [LANES-1:0] ONE = 1;

    logic               clk = 1'b0;
    logic               rst, clr;
    logic [LANES-1:0]   req;
    logic [LANES*W-1:0] price_i, num_i;
    logic [LANES-1:0]   ack;
    logic               busy, avg_valid, ovf;
    logic [W-1:0]       avg;

    sales_arb #(.LANES(LANES), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .price_i   (price_i),
        .num_i     (num_i),
        .clr       (clr),
        .ack       (ack),
        .busy      (busy),
        .avg       (avg),
        .avg_valid (avg_valid),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] avg;
        int           gap;
    } exp_t;

    logic [LANES-1:0] ack_q[$];
    exp_t             avg_q[$];
    exp_t             mon_e;
    int               last_ack_cyc = 0;
    int               n_cmp = 0;
    int               n_err = 0;
    logic [W-1:0]     m_amount, m_total;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack != '0) begin
                if (ack_q.size() > 0) check("ack_lane", 64'(ack), 64'(ack_q.pop_front()));
                else                  check("ack_unexpected", 64'(ack), 64'd0);
                last_ack_cyc = cyc;
            end
            if (avg_valid) begin
                if (avg_q.size() > 0) begin
                    mon_e = avg_q.pop_front();
                    check("avg_value", 64'(avg), 64'(mon_e.avg));
                    check("avg_latency", 64'(cyc - last_ack_cyc), 64'(mon_e.gap));
                end else begin
                    check("avg_valid_unexpected", 64'(avg_valid), 64'd0);
                end
            end
        end
    end

    task automatic model_push(input int lane, input logic [W-1:0] p, input logic [W-1:0] n);
        exp_t e;
        m_amount = m_amount + p * n;
        m_total  = m_total + n;
        e.avg    = (m_total == '0) ? '0 : m_amount / m_total;
        e.gap    = (m_total == '0) ? 1 : W + 1;
        ack_q.push_back(ONE << lane);
        avg_q.push_back(e);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        clr = 1'b0;
        req = '0;
        ack_q.delete();
        avg_q.delete();
        m_amount = '0;
        m_total  = '0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_lane(input int lane, input logic [W-1:0] p, input logic [W-1:0] n);
        price_i[lane*W +: W] = p;
        num_i[lane*W +: W]   = n;
        req[lane]            = 1'b1;
    endtask

    task automatic run_one(input int lane, input logic [W-1:0] p, input logic [W-1:0] n);
        int t0;
        bit seen;
        model_push(lane, p, n);
        @(negedge clk);
        drive_lane(lane, p, n);
        t0   = cyc;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (ack[lane]) seen = 1'b1;
        end
        check("ack_seen", 64'(seen), 64'd1);
        check("ack_latency", 64'(cyc - t0), 64'd1);
        check("busy_at_ack", 64'(busy), 64'd1);
        req[lane] = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            check("busy_high", 64'(busy), 64'd1);
            if (avg_valid) seen = 1'b1;
        end
        check("avg_valid_seen", 64'(seen), 64'd1);
        @(negedge clk);
        check("busy_low", 64'(busy), 64'd0);
        check("avg_valid_pulse", 64'(avg_valid), 64'd0);
    endtask

    task automatic drain(input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge clk);
            if (avg_q.size() == 0 && ack_q.size() == 0 && !busy) idle = 1'b1;
        end
        check("drain", 64'(idle), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ack, prev, t_req;
        bit seen;
        rst     = 1'b1;
        clr     = 1'b0;
        req     = '0;
        price_i = '0;
        num_i   = '0;
        m_amount = '0;
        m_total  = '0;

        // Reset state.
        do_reset(3);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_avg", 64'(avg), 64'd0);
        check("rst_avg_valid", 64'(avg_valid), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);

        // Two sequential transactions: 30/3 = 10, then 50/4 = 12.
        run_one(0, 32'd10, 32'd3);
        run_one(1, 32'd20, 32'd1);
        check("avg_held", 64'(avg), 64'd12);
        check("ovf_clean", 64'(ovf), 64'd0);
        drain(10);

        // All lanes request together: served 0,1,2,3, 35 cycles apart.
        do_reset(2);
        for (int l = 0; l < LANES; l++) model_push(l, W'(5 + 30 * l), W'(l + 1));
        @(negedge clk);
        for (int l = 0; l < LANES; l++) drive_lane(l, W'(5 + 30 * l), W'(l + 1));
        n_ack = 0;
        prev  = 0;
        for (int i = 0; i < 200 && n_ack < LANES; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                req = req & ~ack;
                if (n_ack > 0) check("ack_spacing", 64'(cyc - prev), 64'(W + 3));
                prev = cyc;
                n_ack++;
            end
        end
        check("all_acked", 64'(n_ack), 64'(LANES));
        drain(60);

        // Zero quantity bypasses the divider.
        do_reset(2);
        run_one(0, 32'd99, 32'd0);
        check("zero_avg", 64'(avg), 64'd0);

        // clr and a request in the same idle cycle.
        run_one(3, 32'd8, 32'd2);
        check("pre_clr_avg", 64'(avg), 64'd8);
        @(negedge clk);
        clr = 1'b1;
        drive_lane(2, 32'd6, 32'd3);
        m_amount = '0;
        m_total  = '0;
        model_push(2, 32'd6, 32'd3);
        @(negedge clk);
        check("clr_no_ack", 64'(ack), 64'd0);
        check("clr_avg", 64'(avg), 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        clr = 1'b0;
        @(negedge clk);
        check("clr_then_grant", 64'(ack), 64'(ONE << 2));
        req[2] = 1'b0;
        drain(60);
        check("post_clr_avg", 64'(avg), 64'd6);

        // Reset while dividing discards the transaction.
        ack_q.push_back(ONE << 1);
        @(negedge clk);
        drive_lane(1, 32'd50, 32'd5);
        t_req = cyc;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ack[1]) seen = 1'b1;
        end
        check("div_rst_ack", 64'(seen), 64'd1);
        req[1] = 1'b0;
        repeat (10) @(negedge clk);
        check("div_rst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        avg_q.delete();
        @(negedge clk);
        check("div_rst_avg", 64'(avg), 64'd0);
        check("div_rst_busy", 64'(busy), 64'd0);
        check("div_rst_avg_valid", 64'(avg_valid), 64'd0);
        rst = 1'b0;
        m_amount = '0;
        m_total  = '0;
        repeat (40) @(negedge clk);
        check("div_rst_quiet", 64'(busy), 64'd0);

        // Overflow-sized operands: product 2^32 wraps to zero.
        do_reset(2);
        run_one(0, 32'h0001_0000, 32'h0001_0000);
        check("ovf_case_avg", 64'(avg), 64'd0);
`ifdef SALES_OVF_EN
        check("ovf_set", 64'(ovf), 64'd1);
        @(negedge clk);
        check("ovf_sticky", 64'(ovf), 64'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("ovf_cleared", 64'(ovf), 64'd0);
`else
        check("ovf_tied", 64'(ovf), 64'd0);
`endif
        drain(10);
        check("sb_ack_empty", 64'(ack_q.size()), 64'd0);
        check("sb_avg_empty", 64'(avg_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
